// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle parametrised ALU with start/busy/done handshake
//
// Purpose: single-cycle logic/shift/add ops, iterative radix-4 Booth multiply
// (one bit-pair per cycle) and iterative signed non-restoring divide (one bit
// per cycle). Results and flags are registered on entry to DONE and held until
// the next DONE or clear.
//
// Optional feature: define SEQ_ALU_EARLY_TERM_EN to let MUL finish as soon as
// every remaining Booth digit is zero (same product, shorter latency).
//
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-high reset; aborts any op in flight
//   start        launch op; sampled only while busy=0
//   opcode[4:0]  operation select
//   A, B         operands, latched on the accepting edge
//   busy         op in progress (MUL/DIV/DFIX/DONE)
//   done         one-cycle pulse, results valid from this cycle
//   Chigh, Clow  result: MUL product hi/lo, DIV remainder/quotient
//   ovf          signed overflow (ADD/SUB/NEG/INCPC, DIV most-negative/-1)
//   div_by_zero  DIV with B==0
//   illegal_op   unlisted opcode

module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Chigh,
    output logic [WIDTH-1:0] Clow,
    output logic             ovf,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_SHR   = 5'b00101;
    localparam logic [4:0] OP_SHRA  = 5'b00110;
    localparam logic [4:0] OP_SHL   = 5'b00111;
    localparam logic [4:0] OP_ROR   = 5'b01000;
    localparam logic [4:0] OP_ROL   = 5'b01001;
    localparam logic [4:0] OP_AND   = 5'b01010;
    localparam logic [4:0] OP_OR    = 5'b01011;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_NEG   = 5'b10001;
    localparam logic [4:0] OP_NOT   = 5'b10010;
    localparam logic [4:0] OP_INCPC = 5'b11000;

    localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   MUL_LAST = SHW'(WIDTH/2 - 1);
    localparam logic [SHW-1:0]   DIV_LAST = SHW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DFIX,
        S_DONE
    } state_t;

    state_t state, next_state;

    // iteration state
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] mcand;     // sign-extended A, shifted left 2 per step
    logic [2*WIDTH-1:0] acc;       // product accumulator
    logic [WIDTH:0]     mq;        // {B, 0}, arithmetic-shifted right 2 per step
    logic [WIDTH:0]     rem;       // signed partial remainder
    logic [WIDTH-1:0]   quo;       // dividend magnitude shifts out, quotient in
    logic [WIDTH-1:0]   dvs;       // divisor magnitude
    logic               a_neg;
    logic               q_neg;
    logic               div_ovf;

    logic start_mul, start_div;
    assign start_mul = start && (opcode == OP_MUL);
    assign start_div = start && (opcode == OP_DIV) && (B != '0);

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] sum_ab, diff_ab, neg_b, inc_b, rot_amt;
    logic [WIDTH-1:0] sc_hi, sc_lo;
    logic             sc_ovf, sc_dbz, sc_ill;

    assign sum_ab  = A + B;
    assign diff_ab = A - B;
    assign neg_b   = -B;
    assign inc_b   = B + 1'b1;
    assign rot_amt = B % W_VAL;

    always_comb begin
        sc_hi  = '0;
        sc_lo  = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_lo  = sum_ab;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ab[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo  = diff_ab;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ab[WIDTH-1] != A[WIDTH-1]);
            end
            // shifting by the full B value already yields 0 / sign fill for B>=WIDTH
            OP_SHR:  sc_lo = A >> B;
            OP_SHRA: sc_lo = $signed(A) >>> B;
            OP_SHL:  sc_lo = A << B;
            // rot_amt==0 makes the opposite shift WIDTH wide, which contributes 0
            OP_ROR:  sc_lo = (A >> rot_amt) | (A << (W_VAL - rot_amt));
            OP_ROL:  sc_lo = (A << rot_amt) | (A >> (W_VAL - rot_amt));
            OP_AND:  sc_lo = A & B;
            OP_OR:   sc_lo = A | B;
            OP_NEG: begin
                sc_lo  = neg_b;
                sc_ovf = (B == MIN_VAL);
            end
            OP_NOT:  sc_lo = ~B;
            OP_INCPC: begin
                sc_lo  = inc_b;
                sc_ovf = (B == ~MIN_VAL);
            end
            OP_MUL: ;
            // only reaches DONE directly when B==0
            OP_DIV: begin
                sc_hi  = A;
                sc_lo  = '1;
                sc_dbz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // ---------------- Booth step ----------------
    logic [2*WIDTH-1:0] addend, acc_nxt;
    logic [WIDTH:0]     mq_nxt;
    logic               mul_finish;

    always_comb begin
        addend = '0;
        case (mq[2:0])
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = -(mcand << 1);
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
    end

    assign acc_nxt = acc + addend;
    assign mq_nxt  = {{2{mq[WIDTH]}}, mq[WIDTH:2]};

`ifdef SEQ_ALU_EARLY_TERM_EN
    // all remaining multiplier bits equal the last examined bit -> all digits 0
    assign mul_finish = (cnt == MUL_LAST) || (mq_nxt == '0) || (&mq_nxt);
`else
    assign mul_finish = (cnt == MUL_LAST);
`endif

    // ---------------- non-restoring divide step ----------------
    logic [WIDTH:0]   div_shift, rem_nxt;
    logic [WIDTH-1:0] quo_nxt, rem_lo, q_out, r_out;
    logic [WIDTH-1:0] a_mag, b_mag;

    // rem stays in [-dvs, dvs), so 2*rem+bit fits in WIDTH+1 signed bits
    assign div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign rem_nxt   = rem[WIDTH] ? (div_shift + {1'b0, dvs}) : (div_shift - {1'b0, dvs});
    assign quo_nxt   = {quo[WIDTH-2:0], ~rem_nxt[WIDTH]};

    assign rem_lo = rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
    assign q_out  = q_neg ? -quo : quo;
    assign r_out  = a_neg ? -rem_lo : rem_lo;

    // most-negative magnitude is 2^(WIDTH-1), still exact as unsigned
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_mul)      next_state = S_MUL;
                else if (start_div) next_state = S_DIV;
                else if (start)     next_state = S_DONE;
            end
            S_MUL:  if (mul_finish)      next_state = S_DONE;
            S_DIV:  if (cnt == DIV_LAST) next_state = S_DFIX;
            S_DFIX: next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // ---------------- datapath / result registers ----------------
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt         <= '0;
            mcand       <= '0;
            acc         <= '0;
            mq          <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            a_neg       <= 1'b0;
            q_neg       <= 1'b0;
            div_ovf     <= 1'b0;
            Chigh       <= '0;
            Clow        <= '0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        mcand   <= {{WIDTH{A[WIDTH-1]}}, A};
                        acc     <= '0;
                        mq      <= {B, 1'b0};
                        rem     <= '0;
                        quo     <= a_mag;
                        dvs     <= b_mag;
                        a_neg   <= A[WIDTH-1];
                        q_neg   <= A[WIDTH-1] ^ B[WIDTH-1];
                        div_ovf <= (A == MIN_VAL) && (B == '1);
                        if (!start_mul && !start_div) begin
                            Chigh       <= sc_hi;
                            Clow        <= sc_lo;
                            ovf         <= sc_ovf;
                            div_by_zero <= sc_dbz;
                            illegal_op  <= sc_ill;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 2;
                    mq    <= mq_nxt;
                    cnt   <= cnt + 1'b1;
                    if (mul_finish) begin
                        Chigh       <= acc_nxt[2*WIDTH-1:WIDTH];
                        Clow        <= acc_nxt[WIDTH-1:0];
                        ovf         <= 1'b0;
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                end
                S_DFIX: begin
                    Chigh       <= r_out;
                    Clow        <= q_out;
                    ovf         <= div_ovf;
                    div_by_zero <= 1'b0;
                    illegal_op  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
